// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction path: word width, halt opcode and
// the fetch controller state encoding.
package cpu_pkg;

  localparam int INST_W = 8;
  localparam logic [INST_W-1:0] HALT_OP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Control, load and instruction-handshake bundle between fetch_unit and the
// rest of the core; the slave side is the fetch unit itself.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) ();

  logic              load_en;
  logic [PC_W-1:0]   load_addr;
  logic [INST_W-1:0] load_data;
  logic              start;
  logic [PC_W-1:0]   start_addr;
  logic              jump;
  logic [PC_W-1:0]   jump_addr;
  logic              inst_ready;
  logic              inst_valid;
  logic [INST_W-1:0] inst_reg;
  logic [PC_W-1:0]   pc;
  logic              busy;
  logic              halted;

  modport master (
    output load_en, load_addr, load_data, start, start_addr,
           jump, jump_addr, inst_ready,
    input  inst_valid, inst_reg, pc, busy, halted
  );

  modport slave (
    input  load_en, load_addr, load_data, start, start_addr,
           jump, jump_addr, inst_ready,
    output inst_valid, inst_reg, pc, busy, halted
  );

endinterface

// File: rtl/prog_mem.sv
// Program store: synchronous write port, combinational read port so the fetch
// decision can look at mem[pc] in the same cycle.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PC_W-1:0]   waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [PC_W-1:0]   raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [2**PC_W];

  // No reset: program contents must survive a reset of the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a one-entry valid/ready output slot,
// jump redirect and halt-on-opcode, feeding the decode stage.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.slave bus
);

  fetch_state_t      state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic              valid_reg, valid_next;
  logic [INST_W-1:0] word_reg, word_next;
  logic              busy_reg, halted_reg;
  logic              mem_we;
  logic [INST_W-1:0] mem_rdata;
  logic              slot_free;

  prog_mem #(.PC_W(PC_W)) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_reg),
    .rdata (mem_rdata)
  );

  assign slot_free = !valid_reg || bus.inst_ready;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    valid_next = valid_reg;
    word_next  = word_reg;
    mem_we     = 1'b0;
    unique case (state_reg)
      IDLE, HALT: begin
        mem_we     = bus.load_en;
        valid_next = 1'b0;
        if (bus.start) begin
          pc_next    = bus.start_addr;
          state_next = RUN;
        end
      end
      RUN: begin
        // A jump squashes whatever is held; an accepted word was already consumed.
        if (bus.jump) begin
          pc_next    = bus.jump_addr;
          valid_next = 1'b0;
        end else if (slot_free) begin
          if (mem_rdata == HALT_OP) begin
            valid_next = 1'b0;
            state_next = HALT;
          end else begin
            word_next  = mem_rdata;
            valid_next = 1'b1;
            pc_next    = pc_reg + PC_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      valid_reg  <= 1'b0;
      word_reg   <= '0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      valid_reg  <= valid_next;
      word_reg   <= word_next;
      busy_reg   <= (state_next == RUN);
      halted_reg <= (state_next == HALT);
    end
  end

  assign bus.inst_valid = valid_reg;
  assign bus.inst_reg   = word_reg;
  assign bus.pc         = pc_reg;
  assign bus.busy       = busy_reg;
  assign bus.halted     = halted_reg;

endmodule
